pause_arbiter: RTL and testbench
================================

Name: pause_arbiter

Overview:
- Sequences the core's pause line and shares the game work-RAM port between the running CPU and the hiscore save/restore engine.
- The hiscore engine's request is deferred to a vertical-blank boundary. The core is then paused and allowed to settle before the engine is granted the RAM port.
- Merges the user pause toggle and the screen-dim timer into the same controller.
- Sits in the top level between hps/hiscore logic, the game core and the video output path.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- SETTLE_CYCLES, 4, cycles the core stays paused before grant (min 1).
- VBL_TIMEOUT, 24'h3A980, cycles to wait for vblank before forcing entry (20 ms @ 12 MHz).
- DIM_TIMEOUT, 32'h7270E00, user-pause cycles before dim_video asserts (10 s @ 12 MHz).

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset_n  in  1  asynchronous active-low reset
- user_pause  in  1  pause button level; the rising edge toggles pause
- vblank  in  1  core vertical blank
- hs_req  in  1  hiscore engine access request (level, held for the whole transfer)
- hs_grant  out  1  RAM port granted to the hiscore engine
- hs_addr  in  ADDR_W  hiscore address
- hs_wdata  in  DATA_W  hiscore write data
- hs_we  in  1  hiscore write strobe (honoured only while hs_grant=1)
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_we  in  1  core write strobe
- ram_addr  out  ADDR_W  muxed RAM address
- ram_wdata  out  DATA_W  muxed RAM write data
- ram_we  out  1  muxed RAM write strobe
- pause  out  1  pause to core (= user toggle OR hiscore hold)
- dim_video  out  1  halve RGB intensity
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values (async, reset_n=0):
  - state=IDLE, pause_toggle=0, hs_grant=0, pause=0, dim_video=0, busy=0.
  - Timers cleared; RAM mux selects the CPU side.
- user_pause:
  - Registered once; the rising edge (old=0, new=1) toggles pause_toggle.
  - Holding the button produces no repeat toggles.
- Dim timer (32 bit):
  - Counts +1 per cycle while pause_toggle=1 and saturates at DIM_TIMEOUT.
  - Cleared in the cycle after pause_toggle becomes 0.
  - dim_video = (timer >= DIM_TIMEOUT), registered.
- FSM states and transitions:
  - IDLE:
    - hs_req=1 → WAIT_VBL; vbl_cnt cleared.
    - If pause_toggle=1, the core is already halted: go straight to SETTLE.
  - WAIT_VBL:
    - vblank rising edge → SETTLE.
    - vbl_cnt reaching VBL_TIMEOUT-1 → SETTLE (forced).
    - hs_req drop → IDLE with no grant.
  - SETTLE:
    - hs_hold=1, so pause=1.
    - After SETTLE_CYCLES cycles → GRANT.
    - hs_req drop → RELEASE.
  - GRANT:
    - hs_grant=1; RAM mux selects the hiscore side.
    - ram_we = hs_we & hs_grant; cpu_we is ignored.
    - hs_req drop → RELEASE.
  - RELEASE:
    - hs_grant=0 and mux back to the CPU in this cycle; hs_hold stays 1 for exactly one cycle.
    - Next state IDLE; hs_hold=0.
- Latency:
  - With pause_toggle=0: hs_grant rises SETTLE_CYCLES+1 cycles after the qualifying vblank edge.
  - With pause_toggle=1: hs_grant rises SETTLE_CYCLES+1 cycles after hs_req.
  - pause falls 2 cycles after hs_req drops, unless pause_toggle=1.
- Mux rules:
  - Combinational on state, so the mux never switches while a write strobe is registered.
  - RAM writes are never issued from both sides in one cycle.
- Simultaneous events:
  - User toggle during GRANT updates pause_toggle but never shortens the hold.
  - An hs_req re-assert in RELEASE is ignored until IDLE.
  - A vblank edge and hs_req rising in the same cycle do not count; the next edge is required.
- Reset mid-GRANT: grant drops asynchronously, the mux returns to the CPU and any hiscore write is lost (the engine retries).
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: PAUSE_ARB_OSD_EN.
- When defined:
  - Adds input osd_open (1 bit, clk_sys domain).
  - pause also asserts while osd_open=1; the dim timer counts during OSD pause too.
  - The IDLE shortcut to SETTLE also applies when osd_open=1.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package pause_arb_pkg:
  - State enum arb_state_t {IDLE, WAIT_VBL, SETTLE, GRANT, RELEASE}.
  - Default timeout constants.
- Sub-module pause_dim_timer holds the toggle-edge detect, the saturating counter and the dim compare.
- FSM and RAM mux stay in pause_arbiter.

Test Plan:
- Toggle: user_pause pulses at cycles 10 and 50 → pause 1 from cycle 12, 0 from cycle 52. Holding the button 100 cycles → exactly one toggle.
- Dim: DIM_TIMEOUT=100, pause held → dim_video=1 at cycle ~101 after toggle, stays 1. Un-pause → dim_video=0 within 2 cycles.
- Hiscore at vblank: hs_req=1, vblank edge 30 cycles later, SETTLE_CYCLES=4 → hs_grant rises 5 cycles after the edge. A hs_we write of 0x5A to 0x123 appears on the RAM port with cpu_we=1 suppressed.
- Vblank timeout: VBL_TIMEOUT=64, vblank held 0 → grant at 64+5 cycles.
- Release and overlap:
  - hs_req drop in GRANT → hs_grant=0 next cycle, pause=0 one cycle later.
  - With pause_toggle=1 at drop, pause stays 1.
- Reset: reset_n low mid-GRANT → hs_grant, pause and busy are 0 immediately and ram_addr follows cpu_addr.

Source files
------------

// File: rtl/pause_arb_pkg.sv
// Shared types and default timing constants for the pause/hiscore arbiter.
package pause_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VBL,
        SETTLE,
        GRANT,
        RELEASE
    } arb_state_t;

    localparam int          SETTLE_CYCLES_DEF = 4;
    localparam logic [23:0] VBL_TIMEOUT_DEF   = 24'h3A980;   // 20 ms @ 12 MHz
    localparam logic [31:0] DIM_TIMEOUT_DEF   = 32'h7270E00; // 10 s @ 12 MHz

endpackage

// File: rtl/pause_dim_timer.sv
// User pause toggle (edge detect on the registered button) and the saturating
// screen-dim timer that runs while the core is paused by the user or OSD.
module pause_dim_timer
    import pause_arb_pkg::*;
#(
    parameter logic [31:0] DIM_TIMEOUT = DIM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic user_pause,
    input  logic ext_pause,
    output logic pause_toggle,
    output logic dim_video
);

    logic        btn_q, btn_d;
    logic        btn_prev_q, btn_prev_d;
    logic        toggle_q, toggle_d;
    logic [31:0] timer_q, timer_d;
    logic        dim_q, dim_d;
    logic        active;

    always_comb begin
        btn_d      = user_pause;
        btn_prev_d = btn_q;
        toggle_d   = toggle_q ^ (btn_q & ~btn_prev_q);
        active     = toggle_q | ext_pause;
        timer_d    = '0;
        if (active) begin
            timer_d = (timer_q >= DIM_TIMEOUT) ? timer_q : timer_q + 32'd1;
        end
        // Gated by active so a zero timeout cannot dim an unpaused screen.
        dim_d = active & (timer_d >= DIM_TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q      <= 1'b0;
            btn_prev_q <= 1'b0;
            toggle_q   <= 1'b0;
            timer_q    <= '0;
            dim_q      <= 1'b0;
        end else begin
            btn_q      <= btn_d;
            btn_prev_q <= btn_prev_d;
            toggle_q   <= toggle_d;
            timer_q    <= timer_d;
            dim_q      <= dim_d;
        end
    end

    assign pause_toggle = toggle_q;
    assign dim_video    = dim_q;

endmodule

// File: rtl/pause_arbiter.sv
// Pause sequencing and work-RAM sharing between the core CPU and the hiscore
// engine. Define PAUSE_ARB_OSD_EN to add the osd_open pause input.
module pause_arbiter
    import pause_arb_pkg::*;
#(
    parameter int          ADDR_W        = 12,
    parameter int          DATA_W        = 8,
    parameter int          SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic [23:0] VBL_TIMEOUT   = VBL_TIMEOUT_DEF,
    parameter logic [31:0] DIM_TIMEOUT   = DIM_TIMEOUT_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
`ifdef PAUSE_ARB_OSD_EN
    input  logic              osd_open,
`endif
    input  logic              user_pause,
    input  logic              vblank,
    input  logic              hs_req,
    output logic              hs_grant,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_wdata,
    input  logic              hs_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              pause,
    output logic              dim_video,
    output logic              busy
);

    localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

    arb_state_t          state_q, state_d;
    logic [23:0]         vbl_cnt_q, vbl_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                vbl_prev_q;
    logic                hs_grant_q, hs_hold_q, busy_q;
    logic                pause_toggle;
    logic                ext_pause;
    logic                halted;
    logic                vbl_rise;
    logic                sel_hs;

`ifdef PAUSE_ARB_OSD_EN
    assign ext_pause = osd_open;
`else
    assign ext_pause = 1'b0;
`endif

    pause_dim_timer #(
        .DIM_TIMEOUT (DIM_TIMEOUT)
    ) u_dim (
        .clk          (clk_sys),
        .rst_n        (reset_n),
        .user_pause   (user_pause),
        .ext_pause    (ext_pause),
        .pause_toggle (pause_toggle),
        .dim_video    (dim_video)
    );

    assign halted   = pause_toggle | ext_pause;
    assign vbl_rise = vblank & ~vbl_prev_q;

    always_comb begin
        state_d      = state_q;
        vbl_cnt_d    = vbl_cnt_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            IDLE: begin
                vbl_cnt_d    = '0;
                settle_cnt_d = '0;
                // A halted core needs no vblank alignment.
                if (hs_req) state_d = halted ? SETTLE : WAIT_VBL;
            end
            WAIT_VBL: begin
                if (!hs_req) begin
                    state_d = IDLE;
                end else if (vbl_rise || vbl_cnt_q == VBL_TIMEOUT - 24'd1) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end else begin
                    vbl_cnt_d = vbl_cnt_q + 24'd1;
                end
            end
            SETTLE: begin
                if (!hs_req) begin
                    state_d = RELEASE;
                end else if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_d = GRANT;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            GRANT:   if (!hs_req) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            vbl_cnt_q    <= '0;
            settle_cnt_q <= '0;
            vbl_prev_q   <= 1'b0;
            hs_grant_q   <= 1'b0;
            hs_hold_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vbl_cnt_q    <= vbl_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            vbl_prev_q   <= vblank;
            hs_grant_q   <= (state_d == GRANT);
            hs_hold_q    <= (state_d == SETTLE) || (state_d == GRANT) || (state_d == RELEASE);
            busy_q       <= (state_d != IDLE);
        end
    end

    // Mux decodes the state register directly so it only moves on a clock edge.
    assign sel_hs    = (state_q == GRANT);
    assign ram_addr  = sel_hs ? hs_addr  : cpu_addr;
    assign ram_wdata = sel_hs ? hs_wdata : cpu_wdata;
    assign ram_we    = sel_hs ? (hs_we & hs_grant_q) : cpu_we;

    assign hs_grant = hs_grant_q;
    assign pause    = pause_toggle | ext_pause | hs_hold_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pause_arbiter.sv
// Scoreboard bench for pause_arbiter: timestamped output snapshots and RAM
// writes are queued by the stimulus and checked by independent monitors.
module tb_pause_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              user_pause = 1'b0;
    logic              vblank = 1'b0;
    logic              hs_req = 1'b0;
    logic              hs_grant;
    logic [ADDR_W-1:0] hs_addr = '0;
    logic [DATA_W-1:0] hs_wdata = '0;
    logic              hs_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = 12'h055;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              pause;
    logic              dim_video;
    logic              busy;

    pause_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .SETTLE_CYCLES (4),
        .VBL_TIMEOUT   (24'd64),
        .DIM_TIMEOUT   (32'd100)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
`ifdef PAUSE_ARB_OSD_EN
        .osd_open   (1'b0),
`endif
        .user_pause (user_pause),
        .vblank     (vblank),
        .hs_req     (hs_req),
        .hs_grant   (hs_grant),
        .hs_addr    (hs_addr),
        .hs_wdata   (hs_wdata),
        .hs_we      (hs_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .pause      (pause),
        .dim_video  (dim_video),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // -1 in a field means "don't care".
    typedef struct {
        int    cyc;
        string name;
        int    p, g, b, d, a;
    } snap_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    snap_t exp_q[$];
    wr_t   wr_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic void ex(input int c, input string n, input int p, input int g,
                               input int b, input int d, input int a);
        snap_t s;
        s.cyc = c; s.name = n; s.p = p; s.g = g; s.b = b; s.d = d; s.a = a;
        exp_q.push_back(s);
    endfunction

    function automatic void exw(input int a, input int d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endfunction

    task automatic chk(input string n, input string f, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s.%s @cyc %0d: got 0x%0h expected 0x%0h", n, f, cyc, act, expv);
        end
    endtask

    // Snapshot monitor.
    always @(negedge clk_sys) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            snap_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                chk(e.name, "stale", cyc, e.cyc);
            end else begin
                if (e.p >= 0) chk(e.name, "pause", int'(pause), e.p);
                if (e.g >= 0) chk(e.name, "hs_grant", int'(hs_grant), e.g);
                if (e.b >= 0) chk(e.name, "busy", int'(busy), e.b);
                if (e.d >= 0) chk(e.name, "dim_video", int'(dim_video), e.d);
                if (e.a >= 0) chk(e.name, "ram_addr", int'(ram_addr), e.a);
            end
        end
    end

    // RAM write monitor: every strobe on the port must match the next queued write.
    always @(negedge clk_sys) begin
        if (ram_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("ram_write", "unexpected_we_addr", int'(ram_addr), -1);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("ram_write", "addr", int'(ram_addr), w.addr);
                chk("ram_write", "data", int'(ram_wdata), w.data);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic pulse(input int c);
        wait_cyc(c);
        user_pause = 1'b1;
        wait_cyc(c + 1);
        user_pause = 1'b0;
    endtask

    initial begin
        // Reset state
        ex(2, "reset", 0, 0, 0, 0, 'h055);
        wait_cyc(3);
        reset_n = 1'b1;

        // Toggle on/off
        ex(11, "tog_pre", 0, -1, -1, -1, -1);
        ex(12, "tog_on", 1, 0, 0, 0, -1);
        ex(51, "tog_hold", 1, -1, -1, 0, -1);
        ex(52, "tog_off", 0, -1, -1, -1, -1);
        pulse(10);
        pulse(50);

        // Held button: one toggle, dim after 100 cycles, un-dim on release
        ex(61, "hold_pre", 0, -1, -1, -1, -1);
        ex(62, "hold_on", 1, -1, -1, 0, -1);
        ex(161, "dim_pre", 1, -1, -1, 0, -1);
        ex(162, "dim_on", 1, -1, -1, 1, -1);
        ex(200, "dim_sat", 1, -1, -1, 1, -1);
        ex(212, "unpause", 0, -1, -1, 1, -1);
        ex(213, "undim", 0, -1, -1, 0, -1);
        wait_cyc(60);  user_pause = 1'b1;
        wait_cyc(160); user_pause = 1'b0;
        pulse(210);

        // CPU-side write passes straight through
        exw('h0AB, 'h33);
        wait_cyc(225); cpu_we = 1'b1; cpu_addr = 12'h0AB; cpu_wdata = 8'h33;
        wait_cyc(226); cpu_we = 1'b0;

        // Hiscore access aligned to vblank
        ex(231, "hs_wait", 0, 0, 1, -1, -1);
        ex(260, "hs_wait_end", 0, 0, 1, -1, -1);
        ex(261, "hs_settle", 1, 0, 1, -1, -1);
        ex(264, "hs_settle_end", 1, 0, 1, -1, -1);
        ex(265, "hs_grant", 1, 1, 1, -1, -1);
        ex(275, "hs_grant_hold", 1, 1, 1, -1, -1);
        ex(276, "hs_release", 1, 0, 1, -1, -1);
        ex(277, "hs_idle", 0, 0, 0, -1, -1);
        exw('h123, 'h5A);
        wait_cyc(230); hs_req = 1'b1;
        wait_cyc(260); vblank = 1'b1;
        wait_cyc(266);
        hs_we = 1'b1; hs_addr = 12'h123; hs_wdata = 8'h5A;
        cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'hFF;
        wait_cyc(267); hs_we = 1'b0;
        wait_cyc(268); cpu_we = 1'b0;
        wait_cyc(270); vblank = 1'b0;
        wait_cyc(275); hs_req = 1'b0;

        // Vblank timeout forces entry
        ex(364, "to_wait", 0, 0, 1, -1, -1);
        ex(365, "to_settle", 1, 0, 1, -1, -1);
        ex(368, "to_pre", 1, 0, 1, -1, -1);
        ex(369, "to_grant", 1, 1, 1, -1, -1);
        ex(377, "to_idle", 0, 0, 0, -1, -1);
        wait_cyc(300); hs_req = 1'b1;
        wait_cyc(375); hs_req = 1'b0;

        // Paused core: shortcut to SETTLE; user toggle during GRANT keeps hold
        ex(392, "ov_tog", 1, 0, 0, -1, -1);
        ex(401, "ov_settle", 1, 0, 1, -1, -1);
        ex(404, "ov_pre", 1, 0, 1, -1, -1);
        ex(405, "ov_grant", 1, 1, 1, -1, -1);
        ex(413, "ov_untog", 1, 1, 1, -1, -1);
        ex(421, "ov_release", 1, 0, 1, -1, -1);
        ex(422, "ov_idle", 0, 0, 0, -1, -1);
        pulse(390);
        wait_cyc(400); hs_req = 1'b1;
        pulse(410);
        wait_cyc(420); hs_req = 1'b0;

        // Drop with user pause on; re-request during RELEASE waits for IDLE
        ex(445, "tp_grant", 1, 1, 1, -1, -1);
        ex(451, "tp_release", 1, 0, 1, -1, -1);
        ex(452, "tp_idle", 1, 0, 0, -1, -1);
        ex(453, "tp_resettle", 1, 0, 1, -1, -1);
        ex(456, "tp_pre", 1, 0, 1, -1, -1);
        ex(457, "tp_regrant", 1, 1, 1, -1, -1);
        pulse(430);
        wait_cyc(440); hs_req = 1'b1;
        wait_cyc(450); hs_req = 1'b0;
        wait_cyc(451); hs_req = 1'b1;

        // Reset in GRANT
        ex(459, "rst_pre", 1, 1, 1, -1, 'h0F0);
        ex(460, "rst_mid", 0, 0, 0, 0, 'h3C3);
        wait_cyc(459); hs_addr = 12'h0F0; cpu_addr = 12'h3C3;
        wait_cyc(460); reset_n = 1'b0; hs_req = 1'b0;
        wait_cyc(463); reset_n = 1'b1;

        // Vblank edge coinciding with the request is ignored
        ex(471, "co_wait", 0, 0, 1, -1, -1);
        ex(480, "co_noedge", 0, 0, 1, -1, -1);
        ex(485, "co_pre", 0, 0, 1, -1, -1);
        ex(486, "co_settle", 1, 0, 1, -1, -1);
        ex(489, "co_pre_grant", 1, 0, 1, -1, -1);
        ex(490, "co_grant", 1, 1, 1, -1, -1);
        ex(494, "co_idle", 0, 0, 0, -1, -1);
        wait_cyc(470); hs_req = 1'b1; vblank = 1'b1;
        wait_cyc(482); vblank = 1'b0;
        wait_cyc(485); vblank = 1'b1;
        wait_cyc(492); hs_req = 1'b0;

        wait_cyc(500);
        chk("end", "snapshots_left", exp_q.size(), 0);
        chk("end", "writes_left", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
